// File: rtl/abortable_toggle_cell.sv
// abortable_toggle_cell: queued, delayed bit updates to q that the initiator can retract with abort.
// Ops wait in a small FIFO and commit LATENCY clocks after being dequeued.
module abortable_toggle_cell #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [1:0]                   req_op,
  output logic                         req_ready,
  input  logic                         abort,
  input  logic                         hold,
  output logic                         q,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic [$clog2(DEPTH+2)-1:0]   pending
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(DEPTH + 2);
  typedef enum logic {IDLE, DELAY} state_t;
  state_t          state_q, state_d;
  logic [1:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [FW-1:0]   count_q, count_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            q_q, q_d, done_q, done_d, aborted_q, aborted_d;
  logic            empty, push, expire, commit, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty     = count_q == '0;
  assign req_ready = !abort && (count_q < FW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign expire    = state_q == DELAY && cnt_q == '0;
  assign commit    = !abort && !hold && expire;
  // The next op is popped on the commit edge itself so back-to-back ops commit every LATENCY edges.
  assign pop       = !abort && !hold && !empty && (state_q == IDLE || expire);
  assign busy      = state_q == DELAY;
  assign pending   = NW'(count_q) + NW'(busy);
  assign q         = q_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      q_q       <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      q_q       <= q_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= req_op;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = pop ? nxt(rd_q) : rd_q;
    wr_d      = push ? nxt(wr_q) : wr_q;
    count_d   = count_q + FW'(push) - FW'(pop);
    done_d    = commit;
    aborted_d = abort && pending != '0;
    q_d       = !commit ? q_q :
                op_q == 2'b00 ? ~q_q :
                op_q == 2'b01 ? 1'b0 :
                op_q == 2'b10 ? 1'b1 : q_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      count_d = '0;
      rd_d    = wr_q;
    end else if (pop) begin
      state_d = DELAY;
      cnt_d   = CW'(LATENCY - 1);
      op_d    = mem_q[rd_q];
    end else if (commit) begin
      state_d = IDLE;
    end else if (state_q == DELAY && !hold) begin
      cnt_d = cnt_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_abortable_toggle_cell.sv
// tb_abortable_toggle_cell: directed protocol scenarios then random traffic, checked against a queue-based model.
module tb_abortable_toggle_cell;
  localparam int LAT = 2;
  localparam int DEP = 4;
  logic       clock = 1'b0, reset = 1'b1, req_valid = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic       req_ready, q, busy, done, aborted;
  logic [2:0] pending;
  int         errors = 0, checks = 0;
  bit [1:0]   fq[$];
  bit         inf, mq, mdone, mab;
  bit [1:0]   inop;
  int         rem;
  abortable_toggle_cell #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .abort(abort), .hold(hold), .q(q), .busy(busy),
    .done(done), .aborted(aborted), .pending(pending)
  );
  always #5 clock = ~clock;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic bit apply(input bit [1:0] op, input bit cur);
    case (op)
      2'b00:   return ~cur;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return cur;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_outputs();
    chk("q", 8'(q), 8'(mq));
    chk("busy", 8'(busy), 8'(inf));
    chk("done", 8'(done), 8'(mdone));
    chk("aborted", 8'(aborted), 8'(mab));
    chk("pending", 8'(pending), 8'(fq.size() + int'(inf)));
  endtask
  // One clock edge: drive inputs, check req_ready, advance the model, check registered outputs.
  task automatic cyc(input bit v, input bit [1:0] op, input bit ab, input bit hd);
    bit rdy, psh;
    int pend;
    req_valid = v; req_op = op; abort = ab; hold = hd;
    #2;
    rdy = !ab && fq.size() < DEP;
    chk("req_ready", 8'(req_ready), 8'(rdy));
    psh  = v && rdy;
    pend = fq.size() + int'(inf);
    mdone = 1'b0;
    mab   = 1'b0;
    if (ab) begin
      mab = pend != 0;
      fq.delete();
      inf = 1'b0;
    end else begin
      if (!hd && inf) begin
        rem--;
        if (rem == 0) begin
          mq = apply(inop, mq);
          mdone = 1'b1;
          inf = 1'b0;
        end
      end
      if (!hd && !inf && fq.size() > 0) begin
        inop = fq.pop_front();
        inf = 1'b1;
        rem = LAT;
      end
      if (psh) fq.push_back(op);
    end
    @(posedge clock);
    #1;
    check_outputs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b11, 1'b0, 1'b0);
  endtask
  task automatic mid_reset();
    req_valid = 1'b0; abort = 1'b0; hold = 1'b0;
    #3 reset = 1'b1;
    #1;
    fq.delete(); inf = 1'b0; mq = 1'b0; mdone = 1'b0; mab = 1'b0;
    check_outputs();
    chk("req_ready_rst", 8'(req_ready), 8'd1);
    #10 reset = 1'b0;
  endtask
  initial begin
    #3;
    check_outputs();
    chk("req_ready_rst", 8'(req_ready), 8'd1);
    #9 reset = 1'b0;
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(5);
    chk("q_after_toggle", 8'(q), 8'd1);
    mid_reset();
    chk("q_reset_mid", 8'(q), 8'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b00, 1'b0, 1'b1);
    chk("pending_full", 8'(pending), 8'd4);
    idle(10);
    chk("q_four_toggles", 8'(q), 8'd0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 2'b11, 1'b1, 1'b0);
    idle(4);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(8);
    chk("q_set_clear_toggle", 8'(q), 8'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(1);
    mid_reset();
    idle(5);
    cyc(1'b0, 2'b11, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
